// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter and strobe/stall sequencer for the data memory
module dmem_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int START_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [13:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sign_mask,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [13:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sign_mask,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        busy
);
  localparam logic [3:0] TIMEOUT_CNT = 4'(START_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic        win;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic        m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = mem_mask_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    m0_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    win          = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The memory is not reset with us, so never strobe into a stall still in progress.
        if ((m0_req || m1_req) && !mem_clk_stall) begin
          if (m0_req && m1_req) begin
            win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
          end else begin
            win = m1_req;
          end
          gnt_d        = win;
          last_grant_d = win;
          if (win) begin
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
            mem_mask_d  = m1_sign_mask;
            mem_rd_d    = ~m1_we;
            mem_wr_d    = m1_we;
          end else begin
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
            mem_mask_d  = m0_sign_mask;
            mem_rd_d    = ~m0_we;
            mem_wr_d    = m0_we;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'd0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (mem_clk_stall) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            m0_err_d = ~gnt_q;
            m1_err_d = gnt_q;
            state_d  = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!mem_clk_stall) begin
          if (gnt_q) begin
            m1_rdata_d = mem_read_data;
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = mem_read_data;
            m0_ack_d   = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      mem_addr_q   <= 14'd0;
      mem_wdata_q  <= 32'd0;
      mem_mask_q   <= 4'd0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      m0_ack_q     <= m0_ack_d;
      m0_err_q     <= m0_err_d;
      m1_ack_q     <= m1_ack_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_ack         = m0_ack_q;
  assign m0_err         = m0_err_q;
  assign m0_rdata       = m0_rdata_q;
  assign m1_ack         = m1_ack_q;
  assign m1_err         = m1_err_q;
  assign m1_rdata       = m1_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_memread    = mem_rd_q;
  assign mem_memwrite   = mem_wr_q;
  assign mem_sign_mask  = mem_mask_q;
  assign busy           = busy_q;

endmodule
